// File: rtl/seq_mag_comparator.sv
// Sequential magnitude comparator: walks two WIDTH-bit operands MSB-first,
// DIGIT bits per clock, and exits on the first differing digit.
module seq_mag_comparator #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             signed_mode,
   output logic             busy,
   output logic             done,
   output logic             agtb,
   output logic             altb,
   output logic             aeqb
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0]    LAST_DIG = CW'(NDIG - 1);
   localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

   if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("seq_mag_comparator: WIDTH must be a non-zero multiple of DIGIT");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_r, b_r;
   logic [DIGIT-1:0] dig_a, dig_b;
   logic             accept;
   logic             last_dig;
   logic             busy_nx, done_nx, agtb_nx, altb_nx, aeqb_nx;

   // The operand registers shift left each step, so the digit under test is
   // always the top DIGIT bits: no wide variable-index mux on the compare path.
   assign dig_a    = a_r[WIDTH-1 -: DIGIT];
   assign dig_b    = b_r[WIDTH-1 -: DIGIT];
   assign accept   = start && (state == IDLE || state == DONE);
   assign last_dig = (cnt == LAST_DIG);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // NOTE: every comb output gets a default first, so no path infers a latch.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = CMP;
         CMP:     if (dig_a != dig_b || last_dig) state_nx = DONE;
         DONE:    state_nx = start ? CMP : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy_nx = (state_nx == CMP);
      done_nx = (state_nx == DONE);
      agtb_nx = agtb;
      altb_nx = altb;
      aeqb_nx = aeqb;
      if (accept) begin
         agtb_nx = 1'b0;
         altb_nx = 1'b0;
         aeqb_nx = 1'b0;
      end else if (state == CMP) begin
         if (dig_a > dig_b)      agtb_nx = 1'b1;
         else if (dig_a < dig_b) altb_nx = 1'b1;
         else if (last_dig)      aeqb_nx = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy <= 1'b0;
         done <= 1'b0;
         agtb <= 1'b0;
         altb <= 1'b0;
         aeqb <= 1'b0;
      end else begin
         busy <= busy_nx;
         done <= done_nx;
         agtb <= agtb_nx;
         altb <= altb_nx;
         aeqb <= aeqb_nx;
      end
   end

   // NOTE: the operand shift registers are deliberately left out of reset;
   // they are always loaded on accept before anything reads them.
   always_ff @(posedge clk) begin
      if (accept) begin
         // Flipping the sign bit maps two's complement onto offset binary,
         // so one unsigned digit compare serves both modes.
         a_r <= a ^ (signed_mode ? MSB_MASK : '0);
         b_r <= b ^ (signed_mode ? MSB_MASK : '0);
      end else if (state == CMP) begin
         a_r <= a_r << DIGIT;
         b_r <= b_r << DIGIT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (accept) begin
         cnt <= '0;
      end else if (state == CMP && !last_dig) begin
         cnt <= cnt + 1'b1;
      end
   end

   a_done_onehot : assert property (@(posedge clk) disable iff (reset)
      done |-> $onehot({agtb, altb, aeqb}));

   a_busy_clear : assert property (@(posedge clk) disable iff (reset)
      busy |-> ({agtb, altb, aeqb} == 3'b000));

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed bench for seq_mag_comparator in three configurations:
// 8/2 (multi-digit), 2/1 (legacy 2-bit), 8/8 (single-cycle).
module tb_seq_mag_comparator;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] a_i, b_i;
   logic       sm_i;

   logic busy_o[3], done_o[3], agtb_o[3], altb_o[3], aeqb_o[3];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   seq_mag_comparator #(.WIDTH(8), .DIGIT(2)) u_w8d2 (
      .clk(clk), .reset(reset), .start(start), .a(a_i), .b(b_i),
      .signed_mode(sm_i), .busy(busy_o[0]), .done(done_o[0]),
      .agtb(agtb_o[0]), .altb(altb_o[0]), .aeqb(aeqb_o[0]));

   seq_mag_comparator #(.WIDTH(2), .DIGIT(1)) u_w2d1 (
      .clk(clk), .reset(reset), .start(start), .a(a_i[1:0]), .b(b_i[1:0]),
      .signed_mode(sm_i), .busy(busy_o[1]), .done(done_o[1]),
      .agtb(agtb_o[1]), .altb(altb_o[1]), .aeqb(aeqb_o[1]));

   seq_mag_comparator #(.WIDTH(8), .DIGIT(8)) u_w8d8 (
      .clk(clk), .reset(reset), .start(start), .a(a_i), .b(b_i),
      .signed_mode(sm_i), .busy(busy_o[2]), .done(done_o[2]),
      .agtb(agtb_o[2]), .altb(altb_o[2]), .aeqb(aeqb_o[2]));

   typedef struct {
      int         inst;
      logic [7:0] a;
      logic [7:0] b;
      logic       sm;
      logic [2:0] flags;   // {gt, lt, eq}
      int         k;
      string      name;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [4:0] outs(input int inst);
      return {busy_o[inst], done_o[inst], agtb_o[inst], altb_o[inst], aeqb_o[inst]};
   endfunction

   function automatic logic [2:0] flags(input int inst);
      return {agtb_o[inst], altb_o[inst], aeqb_o[inst]};
   endfunction

   function automatic vec_t mk(input int inst, input logic [7:0] a, input logic [7:0] b,
                               input logic sm, input logic [2:0] f, input int k,
                               input string name);
      vec_t v;
      v.inst = inst; v.a = a; v.b = b; v.sm = sm; v.flags = f; v.k = k; v.name = name;
      return v;
   endfunction

   // Called at the first negedge after the accepting edge; returns at the
   // negedge where done is seen, counting busy cycles on the way.
   task automatic wait_done(input int inst, input string name, output int bcnt, output bit ok);
      bcnt = 0;
      ok   = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (done_o[inst]) begin
            ok = 1'b1;
            break;
         end
         if (busy_o[inst]) begin
            bcnt++;
            check({name, " flags0_busy"}, {29'd0, flags(inst)}, 32'd0);
         end
         @(negedge clk);
      end
   endtask

   task automatic do_cmp(input vec_t v);
      int bcnt;
      bit ok;
      repeat (6) @(negedge clk);
      start = 1'b1; a_i = v.a; b_i = v.b; sm_i = v.sm;
      @(negedge clk);
      start = 1'b0;
      wait_done(v.inst, v.name, bcnt, ok);
      check({v.name, " done_seen"}, {31'd0, ok}, 32'd1);
      check({v.name, " busy_cycles"}, bcnt, v.k);
      check({v.name, " flags"}, {29'd0, flags(v.inst)}, {29'd0, v.flags});
      check({v.name, " onehot"}, {31'd0, $onehot(flags(v.inst))}, 32'd1);
      @(negedge clk);
      check({v.name, " done_pulse"}, {31'd0, done_o[v.inst]}, 32'd0);
   endtask

   initial begin
      int  bcnt;
      bit  ok;
      bit  saw_done;
      logic [1:0] la, lb;
      logic [7:0] ra, rb;
      logic       rs;
      logic [2:0] ref_f;

      // Directed W8/D2 vectors: {gt,lt,eq} and digit count worked out by hand.
      vecs.push_back(mk(0, 8'hC3, 8'h43, 1'b0, 3'b100, 1, "u_c3_43"));
      vecs.push_back(mk(0, 8'h12, 8'h13, 1'b0, 3'b010, 4, "u_12_13"));
      vecs.push_back(mk(0, 8'h5A, 8'h5A, 1'b0, 3'b001, 4, "u_5a_5a"));
      vecs.push_back(mk(0, 8'h24, 8'h28, 1'b0, 3'b010, 3, "u_24_28"));
      vecs.push_back(mk(0, 8'h40, 8'h30, 1'b0, 3'b100, 1, "u_40_30"));
      vecs.push_back(mk(0, 8'h0C, 8'h0E, 1'b0, 3'b010, 4, "u_0c_0e"));
      vecs.push_back(mk(0, 8'h80, 8'h7F, 1'b1, 3'b010, 1, "s_80_7f"));
      vecs.push_back(mk(0, 8'h80, 8'h7F, 1'b0, 3'b100, 1, "u_80_7f"));
      vecs.push_back(mk(0, 8'hFF, 8'hFE, 1'b1, 3'b100, 4, "s_ff_fe"));
      vecs.push_back(mk(0, 8'h85, 8'h84, 1'b1, 3'b100, 4, "s_85_84"));
      vecs.push_back(mk(0, 8'hFF, 8'h01, 1'b1, 3'b010, 1, "s_ff_01"));
      vecs.push_back(mk(0, 8'h00, 8'h00, 1'b1, 3'b001, 4, "s_00_00"));
      // Legacy 2-bit truth table; the MSB decides in one step unless equal.
      for (int ia = 0; ia < 4; ia++) begin
         for (int ib = 0; ib < 4; ib++) begin
            la = 2'(ia);
            lb = 2'(ib);
            vecs.push_back(mk(1, {6'd0, la}, {6'd0, lb}, 1'b0,
                              {ia > ib, ia < ib, ia == ib},
                              (la[1] != lb[1]) ? 1 : 2,
                              $sformatf("leg_%0d_%0d", ia, ib)));
         end
      end

      // Reset state
      reset = 1'b1; start = 1'b0; a_i = '0; b_i = '0; sm_i = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++)
         check($sformatf("reset_outs_%0d", i), {27'd0, outs(i)}, 32'd0);
      reset = 1'b0;

      // Reset mid-CMP aborts without a done pulse
      repeat (2) @(negedge clk);
      start = 1'b1; a_i = 8'h12; b_i = 8'h13;
      @(negedge clk);
      start = 1'b0;
      check("midcmp_busy", {31'd0, busy_o[0]}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("midcmp_reset_outs", {27'd0, outs(0)}, 32'd0);
      reset = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done_o[0] || busy_o[0]) saw_done = 1'b1;
      end
      check("midcmp_no_done", {31'd0, saw_done}, 32'd0);

      for (int i = 0; i < vecs.size(); i++) do_cmp(vecs[i]);

      // Inputs change and start re-pulses while busy: captured values win.
      repeat (6) @(negedge clk);
      start = 1'b1; a_i = 8'h12; b_i = 8'h13; sm_i = 1'b0;
      @(negedge clk);
      start = 1'b0;
      check("hs_ign_busy", {31'd0, busy_o[0]}, 32'd1);
      a_i = 8'hFF; b_i = 8'h00; sm_i = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(0, "hs_ign", bcnt, ok);
      check("hs_ign done_seen", {31'd0, ok}, 32'd1);
      check("hs_ign busy_cycles", bcnt + 1, 4);
      check("hs_ign flags", {29'd0, flags(0)}, 32'b010);
      @(negedge clk);
      check("hs_ign done_pulse", {31'd0, done_o[0]}, 32'd0);
      check("hs_ign no_restart", {31'd0, busy_o[0]}, 32'd0);

      // start held through DONE: back-to-back compare, flags clear in 2nd CMP.
      repeat (6) @(negedge clk);
      start = 1'b1; a_i = 8'h5A; b_i = 8'h5A; sm_i = 1'b0;
      @(negedge clk);
      a_i = 8'hC3; b_i = 8'h43;
      wait_done(0, "b2b_1", bcnt, ok);
      check("b2b_1 done_seen", {31'd0, ok}, 32'd1);
      check("b2b_1 busy_cycles", bcnt, 4);
      check("b2b_1 flags", {29'd0, flags(0)}, 32'b001);
      @(negedge clk);
      start = 1'b0;
      check("b2b_2 done_pulse", {31'd0, done_o[0]}, 32'd0);
      check("b2b_2 busy_next", {31'd0, busy_o[0]}, 32'd1);
      wait_done(0, "b2b_2", bcnt, ok);
      check("b2b_2 done_seen", {31'd0, ok}, 32'd1);
      check("b2b_2 busy_cycles", bcnt, 1);
      check("b2b_2 flags", {29'd0, flags(0)}, 32'b100);
      @(negedge clk);
      check("b2b_2 done_pulse_end", {31'd0, done_o[0]}, 32'd0);

      // Single-cycle configuration against a reference compare.
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom);
         rb = (i % 8 == 0) ? ra : 8'($urandom);
         rs = 1'(i % 2);
         if (rs) ref_f = {$signed(ra) > $signed(rb), $signed(ra) < $signed(rb), ra == rb};
         else    ref_f = {ra > rb, ra < rb, ra == rb};
         do_cmp(mk(2, ra, rb, rs, ref_f, 1, $sformatf("rnd%0d_%h_%h_s%0d", i, ra, rb, rs)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
